// File: rtl/divider_ctrl_if.sv
// Handshake, configuration and status bundle for divider_ctrl.
// The slave modport is the controller's view; the master modport is the requester's.
interface divider_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             enable;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_on_time;
    logic             cfg_ready;
    logic             cfg_err;
    logic             div_out;
    logic             period_tick;
    logic             busy;

    modport master (
        output enable, cfg_valid, cfg_period, cfg_on_time,
        input  cfg_ready, cfg_err, div_out, period_tick, busy
    );

    modport slave (
        input  enable, cfg_valid, cfg_period, cfg_on_time,
        output cfg_ready, cfg_err, div_out, period_tick, busy
    );
endinterface

// File: rtl/divider_ctrl.sv
// Programmable clock divider with a one-deep configuration buffer.
// Updates that arrive while running take effect only at a period wrap, so periods never mix.
module divider_ctrl #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned DEF_PERIOD = 6,
    parameter int unsigned DEF_ON     = 3
) (
    input logic           clk,
    input logic           reset,
    divider_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] RST_ON     = CNT_W'(DEF_ON);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] act_period, act_period_nx;
    logic [CNT_W-1:0] act_on, act_on_nx;
    logic [CNT_W-1:0] pend_period, pend_period_nx;
    logic [CNT_W-1:0] pend_on, pend_on_nx;
    logic             pend_valid, pend_valid_nx;
    logic             div_q;
    logic             err_q;
    logic             running;
    logic             wrap;
    logic             hs;
    logic             cfg_ok;

    assign running = (state != IDLE);
    assign wrap    = running && (cnt == act_period - CNT_W'(1));
    assign hs      = bus.cfg_valid && !pend_valid;
    assign cfg_ok  = (bus.cfg_period >= CNT_W'(2)) &&
                     (bus.cfg_on_time != '0) &&
                     (bus.cfg_on_time < bus.cfg_period);

    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        unique case (state)
            IDLE: begin
                if (bus.enable) state_nx = RUN;
            end
            RUN, STOPPING: begin
                if (wrap) begin
                    state_nx = bus.enable ? RUN : IDLE;
                end else begin
                    cnt_nx   = cnt + CNT_W'(1);
                    state_nx = bus.enable ? RUN : STOPPING;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A pending slot left over when the divider returns to IDLE is applied immediately.
    always_comb begin
        act_period_nx  = act_period;
        act_on_nx      = act_on;
        pend_period_nx = pend_period;
        pend_on_nx     = pend_on;
        pend_valid_nx  = pend_valid;
        if (pend_valid && (wrap || !running)) begin
            act_period_nx = pend_period;
            act_on_nx     = pend_on;
            pend_valid_nx = 1'b0;
        end
        if (hs && cfg_ok) begin
            if (running) begin
                pend_period_nx = bus.cfg_period;
                pend_on_nx     = bus.cfg_on_time;
                pend_valid_nx  = 1'b1;
            end else begin
                act_period_nx = bus.cfg_period;
                act_on_nx     = bus.cfg_on_time;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            act_period  <= RST_PERIOD;
            act_on      <= RST_ON;
            pend_period <= '0;
            pend_on     <= '0;
            pend_valid  <= 1'b0;
            div_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            act_period  <= act_period_nx;
            act_on      <= act_on_nx;
            pend_period <= pend_period_nx;
            pend_on     <= pend_on_nx;
            pend_valid  <= pend_valid_nx;
            // Registered from next-state values so div_out lines up with cnt.
            div_q       <= (state_nx != IDLE) && (cnt_nx < act_on_nx);
            err_q       <= hs && !cfg_ok;
        end
    end

    assign bus.div_out     = div_q;
    assign bus.period_tick = wrap;
    assign bus.busy        = running;
    assign bus.cfg_ready   = !pend_valid;
    assign bus.cfg_err     = err_q;
endmodule

// File: doc/divider_ctrl.md
DIVIDER_CTRL -- requirements
Module: divider_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of counter and config fields.
REQ-002 Parameter DEF_PERIOD, default 6: active period loaded at reset.
REQ-003 Parameter DEF_ON, default 3: active on-time loaded at reset.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low; asserted (0) clears state immediately, independent of clk.
REQ-006 enable  in  1  level request to run the divided output.
REQ-007 cfg_valid  in  1  new configuration offered.
REQ-008 cfg_period  in  CNT_W  requested output period, in clk cycles.
REQ-009 cfg_on_time  in  CNT_W  requested high time, in clk cycles.
REQ-010 cfg_ready  out  1  controller can accept a configuration.
REQ-011 cfg_err  out  1  one-cycle pulse: offered configuration rejected.
REQ-012 div_out  out  1  divided clock output, registered.
REQ-013 period_tick  out  1  one-cycle pulse in the last cycle of each period.
REQ-014 busy  out  1  high in RUN or STOPPING.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and STOPPING.
REQ-016 Active config (act_period, act_on) SHALL drive the counter; a single pending slot (pend_valid, pend_period, pend_on) SHALL buffer one update.
REQ-017 cfg_ready SHALL equal !pend_valid.
REQ-018 A handshake SHALL occur when cfg_valid && cfg_ready; there is no effect otherwise.
REQ-019 A configuration SHALL be valid iff period >= 2 and 1 <= on_time < period.
REQ-020 An invalid handshaken configuration SHALL be dropped, pulse cfg_err on the next cycle and leave active/pending config unchanged.
REQ-021 Valid config in IDLE: SHALL become active on the next edge; pend_valid SHALL stay 0.
REQ-022 Valid config in RUN/STOPPING: SHALL go to pending; it SHALL be applied at the edge where cnt wraps, and pend_valid SHALL clear on that edge.
REQ-023 Counter cnt SHALL run 0..act_period-1 and then wrap to 0; it SHALL hold 0 in IDLE.
REQ-024 div_out SHALL be 1 for cnt in [0, act_on-1] and 0 otherwise in RUN/STOPPING; it SHALL be 0 in IDLE.
REQ-025 period_tick SHALL be 1 iff busy && cnt == act_period-1.
REQ-026 IDLE->RUN SHALL occur when enable=1; the first RUN cycle has cnt=0 and div_out=1.
REQ-027 RUN->STOPPING SHALL occur when enable=0; the current period completes unchanged.
REQ-028 STOPPING->IDLE SHALL occur at the period wrap; STOPPING->RUN SHALL occur if enable=1 again, with no phase disturbance.
REQ-029 enable=0 and wrap in the same cycle while in RUN SHALL go directly to IDLE.
REQ-030 Handshake in the same cycle as a wrap SHALL go to pending; it is applied at the following wrap.
REQ-031 Output period length SHALL never be truncated or mixed between configurations (glitch-free).

Reset
REQ-032 While reset=0: state=IDLE, cnt=0, act_period=DEF_PERIOD, act_on=DEF_ON, pend_valid=0, div_out=0, period_tick=0, cfg_err=0, busy=0, cfg_ready=1.
REQ-033 Reset asserted mid-period SHALL abort immediately; a pending config SHALL be discarded.

Verification
REQ-034 Reset release, enable=1 -> div_out pattern 111000 repeating, period_tick every 6th cycle.
REQ-035 In RUN, cfg (10,2) mid-period -> cfg_ready=0 until wrap; the current 6-cycle period finishes, then 1100000000.
REQ-036 cfg (4,4) or (1,0) -> cfg_err pulse next cycle, config and waveform unchanged.
REQ-037 enable dropped at cnt=1 -> STOPPING, period completes, IDLE after the wrap; re-raise at cnt=4 -> RUN with no gap.
REQ-038 reset=0 asynchronously at cnt=2 with pending -> outputs cleared before the next edge; after release, defaults 6/3 are active.
